// File: rtl/mem_bus_responder.sv
// Word-RAM bus responder: one request at a time, fixed wait states, held response handshake.
// Optional `BUS_RESP_ERR_EN: out-of-window addresses return rsp_err=1 instead of aliasing into RAM.
module mem_bus_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | request latched, counting wait states
  // S_RESP | response presented, waiting for rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, enter_resp;

  logic              lat_write, lat_err;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  req_idx;
  logic              req_err;

  assign offset  = req_addr - BASE_ADDR;
  assign req_idx = offset[IDX_W+1:2];

`ifdef BUS_RESP_ERR_EN
  // addresses below BASE_ADDR wrap to large offsets and land out of range too
  assign req_err = (offset[ADDR_W-1:IDX_W+2] != '0);
  logic unused_bits;
  assign unused_bits = ^offset[1:0];
`else
  assign req_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};
`endif

  // WAIT always lasts WAIT_CYCLES+1 cycles so the response rises WAIT_CYCLES+1 edges after accept
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_err   <= req_err;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= lat_err;
        rsp_rdata <= (lat_write || lat_err) ? '0 : ram[lat_idx];
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // RAM is not reset; the write lands on the same edge the response is raised
  always_ff @(posedge clk) begin
    if (enter_resp && lat_write && !lat_err) ram[lat_idx] <= lat_wdata;
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (2 and 0 wait states) against a transaction-level model.
module tb_mem_bus_responder;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        req_valid_v [2], req_ready_v [2], req_write_v [2];
  logic        rsp_valid_v [2], rsp_ready_v [2], rsp_err_v [2];
  logic [31:0] req_addr_v [2], req_wdata_v [2], rsp_rdata_v [2];

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.WAIT_CYCLES(W0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_write(req_write_v[0]), .req_addr(req_addr_v[0]), .req_wdata(req_wdata_v[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]), .rsp_rdata(rsp_rdata_v[0]),
    .rsp_err(rsp_err_v[0]));

  mem_bus_responder #(.WAIT_CYCLES(W1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_write(req_write_v[1]), .req_addr(req_addr_v[1]), .req_wdata(req_wdata_v[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]), .rsp_rdata(rsp_rdata_v[1]),
    .rsp_err(rsp_err_v[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: transactions, not states ----------------
  logic [31:0] mem_m [2][64];
  bit          known_m [2][64];
  bit          pend [2];
  int          resp_at [2];
  bit          p_wr [2], p_err [2];
  logic [31:0] p_addr [2], p_wdata [2];
  logic [31:0] e_data [2];
  bit          e_known [2], e_err [2];

  function automatic int wcyc(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic bit m_err(input logic [31:0] a);
`ifdef BUS_RESP_ERR_EN
    return a >= 32'd256;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(a >> 2) % 64;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; resp_at[i] = 0; e_known[i] = 0; e_err[i] = 0; e_data[i] = 0;
      for (int k = 0; k < 64; k++) known_m[i][k] = 0;
    end
  end

  // response is due WAIT+1 edges after the accept edge; effects land on that edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        pend[i] <= 0;
      end else if (pend[i]) begin
        if (cyc >= resp_at[i] && rsp_ready_v[i]) begin
          pend[i] <= 0;
        end else if (cyc + 1 == resp_at[i]) begin
          e_err[i] <= p_err[i];
          if (p_err[i] || p_wr[i]) begin
            e_data[i]  <= 32'h0;
            e_known[i] <= 1;
          end else begin
            e_data[i]  <= mem_m[i][m_idx(p_addr[i])];
            e_known[i] <= known_m[i][m_idx(p_addr[i])];
          end
          if (p_wr[i] && !p_err[i]) begin
            mem_m[i][m_idx(p_addr[i])]   <= p_wdata[i];
            known_m[i][m_idx(p_addr[i])] <= 1;
          end
        end
      end else if (req_valid_v[i]) begin
        pend[i]    <= 1;
        resp_at[i] <= cyc + 1 + wcyc(i) + 1;
        p_wr[i]    <= req_write_v[i];
        p_addr[i]  <= req_addr_v[i];
        p_wdata[i] <= req_wdata_v[i];
        p_err[i]   <= m_err(req_addr_v[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp_valid%0d", i), {31'h0, rsp_valid_v[i]},
          {31'h0, reset && pend[i] && (cyc >= resp_at[i])});
      chk($sformatf("req_ready%0d", i), {31'h0, req_ready_v[i]}, {31'h0, !(reset && pend[i])});
      if (reset && pend[i] && (cyc >= resp_at[i])) begin
        if (e_known[i]) chk($sformatf("rsp_rdata%0d", i), rsp_rdata_v[i], e_data[i]);
        chk($sformatf("rsp_err%0d", i), {31'h0, rsp_err_v[i]}, {31'h0, e_err[i]});
      end else if (!reset) begin
        chk($sformatf("rst_rdata%0d", i), rsp_rdata_v[i], 32'h0);
        chk($sformatf("rst_err%0d", i), {31'h0, rsp_err_v[i]}, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit acc = 0;
    req_valid_v[i] = 1; req_write_v[i] = wr; req_addr_v[i] = a; req_wdata_v[i] = d;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = req_ready_v[i];
      @(posedge clk); #1;
      n++;
    end
    req_valid_v[i] = 0;
    acc_cyc = cyc;
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic finish(input int i, input int hold, output logic [31:0] data,
                        output logic err, output int lat);
    int n = 0;
    while (!rsp_valid_v[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = cyc - acc_cyc;
    if (!rsp_valid_v[i]) chk("rsp_timeout", 32'h0, 32'h1);
    chk("ready_in_resp", {31'h0, req_ready_v[i]}, 32'h0);
    data = rsp_rdata_v[i];
    err  = rsp_err_v[i];
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready_v[i] = 1;
    @(posedge clk); #1;
    rsp_ready_v[i] = 0;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid_v[i] = 0; req_write_v[i] = 0; req_addr_v[i] = 0;
      req_wdata_v[i] = 0; rsp_ready_v[i] = 0;
    end
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, rsp_valid_v[0]}, 32'h0);
    chk("reset_rdata", rsp_rdata_v[0], 32'h0);
    chk("reset_err", {31'h0, rsp_err_v[0]}, 32'h0);
    chk("reset_ready", {31'h0, req_ready_v[0]}, 32'h1);
    reset = 1;
    @(posedge clk); #1;

    // write then read back, 2 wait states
    issue(0, 1, 32'h10, 32'hDEADBEEF); finish(0, 0, d, e, lat);
    chk("t1_wr_lat", lat, 3); chk("t1_wr_rdata", d, 32'h0);
    issue(0, 0, 32'h10, 32'h0); finish(0, 0, d, e, lat);
    chk("t1_rd_lat", lat, 3); chk("t1_rd_data", d, 32'hDEADBEEF); chk("t1_rd_err", {31'h0, e}, 32'h0);

    // byte-address low bits are ignored
    issue(0, 1, 32'h0C, 32'h0BADF00D); finish(0, 0, d, e, lat);
    issue(0, 0, 32'h0F, 32'h0); finish(0, 0, d, e, lat);
    chk("t6_lowbits", d, 32'h0BADF00D);

    // backpressure with a second request held; it is taken only in the next idle cycle
    issue(0, 0, 32'h10, 32'h0);
    req_valid_v[0] = 1; req_write_v[0] = 0; req_addr_v[0] = 32'h0C;
    finish(0, 5, d, e, lat);
    chk("t3_data", d, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid_v[0] = 0;
    acc_cyc = cyc;
    finish(0, 0, d, e, lat);
    chk("t3_second_lat", lat, 3); chk("t3_second_data", d, 32'h0BADF00D);

    // reset in the middle of a write's wait states
    issue(0, 1, 32'h08, 32'h11112222); finish(0, 0, d, e, lat);
    issue(0, 0, 32'h08, 32'h0); finish(0, 0, d, e, lat);
    chk("t4_pre", d, 32'h11112222);
    issue(0, 1, 32'h08, 32'hAAAA5555);
    reset = 0;
    #1;
    chk("t4_valid", {31'h0, rsp_valid_v[0]}, 32'h0);
    chk("t4_rdata", rsp_rdata_v[0], 32'h0);
    chk("t4_err", {31'h0, rsp_err_v[0]}, 32'h0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    issue(0, 0, 32'h08, 32'h0); finish(0, 0, d, e, lat);
    chk("t4_old_value", d, 32'h11112222);

    // beyond the RAM window
    issue(0, 1, 32'h000, 32'hCAFEF00D); finish(0, 0, d, e, lat);
    issue(0, 0, 32'h100, 32'h0); finish(0, 0, d, e, lat);
`ifdef BUS_RESP_ERR_EN
    chk("t5_data", d, 32'h0); chk("t5_err", {31'h0, e}, 32'h1);
`else
    chk("t5_data", d, 32'hCAFEF00D); chk("t5_err", {31'h0, e}, 32'h0);
`endif

    // zero wait states; rsp_ready in idle must be ignored
    rsp_ready_v[1] = 1;
    repeat (3) @(posedge clk);
    #1 rsp_ready_v[1] = 0;
    issue(1, 1, 32'h04, 32'h12345678); finish(1, 0, d, e, lat);
    chk("t2_wr_lat", lat, 1);
    issue(1, 0, 32'h04, 32'h0); finish(1, 2, d, e, lat);
    chk("t2_rd_lat", lat, 1); chk("t2_rd_data", d, 32'h12345678);
    issue(1, 0, 32'h104, 32'h0); finish(1, 0, d, e, lat);
`ifdef BUS_RESP_ERR_EN
    chk("t2_alias", d, 32'h0);
`else
    chk("t2_alias", d, 32'h12345678);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
